episode_controller: RTL and testbench

EPISODE_CONTROLLER -- requirements
Module: episode_controller

---
 rtl/episode_controller.sv | 145 ++++++++++++++
 tb/tb_episode_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/episode_controller.sv
// Episode sequencer for a Q-learning datapath: starts episodes, issues random
// actions from a Galois LFSR, detects episode ends and signals run completion.
module episode_controller #(
  parameter int unsigned STATES_WIDTH  = 4,
  parameter int unsigned ACTIONS_WIDTH = 2,
  parameter int unsigned START_ST      = 0,
  parameter int unsigned GOAL_ST       = 15,
  parameter int unsigned MAX_STEPS     = 64,
  parameter int unsigned EPISODES      = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     i_valid_st,
  input  logic [STATES_WIDTH-1:0]  i_st,
  input  logic                     i_update_done,
  output logic                     o_start,
  output logic [STATES_WIDTH-1:0]  o_first_st,
  output logic [ACTIONS_WIDTH-1:0] o_at,
  output logic                     o_valid_at,
  output logic                     o_finish,
  output logic                     o_busy,
  output logic [15:0]              o_episode_cnt
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

  localparam logic [STATES_WIDTH-1:0] GOAL_C      = STATES_WIDTH'(GOAL_ST);
  localparam logic [15:0]             MAX_STEPS_C = 16'(MAX_STEPS);
  localparam logic [15:0]             EPISODES_C  = 16'(EPISODES);

  state_e                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [15:0]              step_q, step_d;
  logic                     goal_q, goal_d;
  logic [15:0]              ep_cnt_q, ep_cnt_d;
  logic                     start_q, start_d;
  logic                     valid_at_q, valid_at_d;
  logic                     finish_q, finish_d;
  logic                     busy_q, busy_d;
  logic [ACTIONS_WIDTH-1:0] at_q, at_d;

  logic        goal_now;
  logic        goal_hit;
  logic [15:0] step_inc;
  logic [15:0] ep_inc;

  always_comb begin
    // NOTE: every _d gets a default first so no latch is inferred on any path.
    state_d    = state_q;
    lfsr_d     = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
    step_d     = step_q;
    goal_d     = goal_q;
    ep_cnt_d   = ep_cnt_q;
    start_d    = 1'b0;
    valid_at_d = 1'b0;
    finish_d   = 1'b0;
    at_d       = at_q;

    goal_now = i_valid_st && (i_st == GOAL_C);
    // A goal seen in the same cycle as the write-back still ends this step.
    goal_hit = goal_q || goal_now;
    step_inc = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
    ep_inc   = ep_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d    = START;
          start_d    = 1'b1;
          valid_at_d = 1'b1;
          at_d       = lfsr_d[ACTIONS_WIDTH-1:0];
          step_d     = '0;
          goal_d     = 1'b0;
          ep_cnt_d   = '0;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (goal_now) goal_d = 1'b1;
        if (i_update_done) begin
          step_d = step_inc;
          if (goal_hit || (step_inc == MAX_STEPS_C)) begin
            ep_cnt_d = ep_inc;
            step_d   = '0;
            goal_d   = 1'b0;
            if (ep_inc == EPISODES_C) begin
              state_d  = DONE;
              finish_d = 1'b1;
            end else begin
              state_d    = START;
              start_d    = 1'b1;
              valid_at_d = 1'b1;
              at_d       = lfsr_d[ACTIONS_WIDTH-1:0];
            end
          end else begin
            valid_at_d = 1'b1;
            at_d       = lfsr_d[ACTIONS_WIDTH-1:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      step_q     <= '0;
      goal_q     <= 1'b0;
      ep_cnt_q   <= '0;
      start_q    <= 1'b0;
      valid_at_q <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      at_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      step_q     <= step_d;
      goal_q     <= goal_d;
      ep_cnt_q   <= ep_cnt_d;
      start_q    <= start_d;
      valid_at_q <= valid_at_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      at_q       <= at_d;
    end
  end

  assign o_first_st    = STATES_WIDTH'(START_ST);
  assign o_start       = start_q;
  assign o_valid_at    = valid_at_q;
  assign o_finish      = finish_q;
  assign o_busy        = busy_q;
  assign o_at          = at_q;
  assign o_episode_cnt = ep_cnt_q;

endmodule

// File: tb/tb_episode_controller.sv
// Scoreboard bench: three controller instances with different step/episode caps;
// expected pulses are queued when stimulus is driven and matched by a monitor.
module tb_episode_controller;

  logic       clk;
  logic       rst_n;
  logic       en[3];
  logic       vst[3];
  logic       upd[3];
  logic [3:0] st[3];
  logic       o_start[3];
  logic       o_valid_at[3];
  logic       o_finish[3];
  logic       o_busy[3];
  logic [3:0] o_first_st[3];
  logic [1:0] o_at[3];
  logic [15:0] o_ep[3];

  // Pulse kinds as {o_start, o_valid_at, o_finish}.
  localparam logic [2:0] K_START  = 3'b110;
  localparam logic [2:0] K_VALID  = 3'b010;
  localparam logic [2:0] K_FINISH = 3'b001;

  typedef struct {
    int          d;
    logic [2:0]  kind;
    logic [1:0]  at;
    logic [15:0] ep;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic [15:0] m_lfsr;
  int          m_steps[3];
  bit          m_goal[3];
  int          m_ep[3];
  bit          m_run[3];
  logic [1:0]  last_at[3];
  int          starts_seen[3];
  int          finishes_seen[3];

  episode_controller #(.MAX_STEPS(3), .EPISODES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_enable(en[0]), .i_valid_st(vst[0]), .i_st(st[0]),
    .i_update_done(upd[0]), .o_start(o_start[0]), .o_first_st(o_first_st[0]),
    .o_at(o_at[0]), .o_valid_at(o_valid_at[0]), .o_finish(o_finish[0]),
    .o_busy(o_busy[0]), .o_episode_cnt(o_ep[0]));

  episode_controller #(.MAX_STEPS(4), .EPISODES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_enable(en[1]), .i_valid_st(vst[1]), .i_st(st[1]),
    .i_update_done(upd[1]), .o_start(o_start[1]), .o_first_st(o_first_st[1]),
    .o_at(o_at[1]), .o_valid_at(o_valid_at[1]), .o_finish(o_finish[1]),
    .o_busy(o_busy[1]), .o_episode_cnt(o_ep[1]));

  episode_controller #(.MAX_STEPS(1), .EPISODES(100)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_enable(en[2]), .i_valid_st(vst[2]), .i_st(st[2]),
    .i_update_done(upd[2]), .o_start(o_start[2]), .o_first_st(o_first_st[2]),
    .o_at(o_at[2]), .o_valid_at(o_valid_at[2]), .o_finish(o_finish[2]),
    .o_busy(o_busy[2]), .o_episode_cnt(o_ep[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Taps of x^16+x^14+x^13+x^11+1 land on bits 15,13,12,10 after the right shift.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) begin
      n[15] = 1'b1;
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int max_steps(input int d);
    case (d)
      0:       return 3;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int episodes(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 100;
    endcase
  endfunction

  // Called at a negedge: the pulse is due right after the next rising edge.
  task automatic push_exp(input int d, input logic [2:0] kind);
    exp_t        e;
    logic [15:0] nx;
    nx     = lfsr_next(m_lfsr);
    e.d    = d;
    e.kind = kind;
    e.at   = nx[1:0];
    e.ep   = 16'(m_ep[d]);
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  exp_t        mon_e;
  logic [2:0]  obs;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) last_at[d] = 2'b00;
    end else begin
      for (int d = 0; d < 3; d++) begin
        obs = {o_start[d], o_valid_at[d], o_finish[d]};
        if (obs != 3'b000) begin
          if (sb.size() == 0 || sb[0].d != d) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_pulse dut%0d cyc %0d: got %b, required none", d, cyc, obs);
          end else begin
            mon_e = sb.pop_front();
            n_vec++;
            if (obs !== mon_e.kind) begin
              n_err++;
              $display("FAIL pulse_kind dut%0d cyc %0d: got %b, required %b", d, cyc, obs, mon_e.kind);
            end
            n_vec++;
            if (cyc != mon_e.cyc) begin
              n_err++;
              $display("FAIL issue_latency dut%0d: got cyc %0d, required cyc %0d", d, cyc, mon_e.cyc);
            end
            n_vec++;
            if (o_ep[d] !== mon_e.ep) begin
              n_err++;
              $display("FAIL episode_cnt dut%0d cyc %0d: got %0d, required %0d", d, cyc, o_ep[d], mon_e.ep);
            end
            if (mon_e.kind[1]) begin
              n_vec++;
              if (o_at[d] !== mon_e.at) begin
                n_err++;
                $display("FAIL action dut%0d cyc %0d: got %0d, required %0d", d, cyc, o_at[d], mon_e.at);
              end
              last_at[d] = mon_e.at;
            end
            if (o_start[d])  starts_seen[d]++;
            if (o_finish[d]) finishes_seen[d]++;
          end
        end else begin
          n_vec++;
          if (o_at[d] !== last_at[d]) begin
            n_err++;
            $display("FAIL action_hold dut%0d cyc %0d: got %0d, required %0d", d, cyc, o_at[d], last_at[d]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_enable(input int d);
    en[d] = 1'b1;
    if (!m_run[d]) begin
      m_run[d] = 1'b1; m_steps[d] = 0; m_goal[d] = 1'b0; m_ep[d] = 0;
      push_exp(d, K_START);
    end
    @(negedge clk);
    en[d] = 1'b0;
  endtask

  task automatic drive_state(input int d, input logic [3:0] s);
    vst[d] = 1'b1;
    st[d]  = s;
    if (m_run[d] && s == 4'hF) m_goal[d] = 1'b1;
    @(negedge clk);
    vst[d] = 1'b0;
    st[d]  = 4'h0;
  endtask

  task automatic drive_update(input int d, input bit goal_now);
    upd[d] = 1'b1;
    if (goal_now) begin
      vst[d] = 1'b1;
      st[d]  = 4'hF;
    end
    if (m_run[d]) begin
      m_steps[d]++;
      if (m_goal[d] || goal_now || m_steps[d] == max_steps(d)) begin
        m_ep[d]++;
        m_steps[d] = 0;
        m_goal[d]  = 1'b0;
        if (m_ep[d] == episodes(d)) begin
          m_run[d] = 1'b0;
          push_exp(d, K_FINISH);
        end else begin
          push_exp(d, K_START);
        end
      end else begin
        push_exp(d, K_VALID);
      end
    end
    @(negedge clk);
    upd[d] = 1'b0;
    vst[d] = 1'b0;
    st[d]  = 4'h0;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({o_start[d], o_valid_at[d], o_finish[d], o_busy[d]} !== 4'b0000 ||
          o_at[d] !== 2'b00 || o_ep[d] !== 16'd0 || o_first_st[d] !== 4'd0) begin
        n_err++;
        $display("FAIL %s dut%0d: got start=%b valid=%b finish=%b busy=%b at=%0d ep=%0d first=%0d, required all 0",
                 tag, d, o_start[d], o_valid_at[d], o_finish[d], o_busy[d], o_at[d], o_ep[d], o_first_st[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
  endtask

  task automatic test_first_issue();
    rst_n = 1'b1;
    drive_enable(0);
    n_vec++;
    // One Galois step from 16'hACE1 gives 16'hE270, so the first action is 0.
    if (o_at[0] !== 2'd0) begin
      n_err++; $display("FAIL first_action: got %0d, required 0", o_at[0]);
    end
    n_vec++;
    if (o_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL first_busy: got %b, required 1", o_busy[0]);
    end
  endtask

  task automatic test_step_cap();
    for (int i = 0; i < 3; i++) begin
      tick(4);
      drive_update(0, 1'b0);
    end
    tick(3);
    n_vec++;
    if (o_busy[0] !== 1'b0 || o_ep[0] !== 16'd1) begin
      n_err++; $display("FAIL step_cap_end: got busy=%b ep=%0d, required busy=0 ep=1", o_busy[0], o_ep[0]);
    end
  endtask

  task automatic test_ignored_inputs();
    drive_update(0, 1'b0);
    tick(1);
    drive_state(0, 4'hF);
    tick(3);
    n_vec++;
    if (o_busy[0] !== 1'b0 || o_ep[0] !== 16'd1) begin
      n_err++; $display("FAIL idle_hold: got busy=%b ep=%0d, required busy=0 ep=1", o_busy[0], o_ep[0]);
    end
    drive_enable(0);
    tick(2);
    drive_enable(0);
    tick(2);
    drive_update(0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    tick(2);
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    m_run[0] = 1'b0;
    m_steps[0] = 0;
    m_goal[0] = 1'b0;
    m_ep[0] = 0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_idle_outputs("post_reset_quiet");
  endtask

  task automatic test_goal();
    drive_enable(1);
    tick(2);
    drive_update(1, 1'b0);
    tick(2);
    drive_state(1, 4'h5);
    tick(1);
    drive_state(1, 4'hF);
    tick(1);
    drive_update(1, 1'b0);
    // The next episode must run the full four steps from a cleared counter.
    for (int i = 0; i < 4; i++) begin
      tick(2);
      drive_update(1, 1'b0);
    end
  endtask

  task automatic test_same_cycle_goal();
    tick(2);
    drive_update(1, 1'b1);
    tick(3);
    n_vec++;
    if (o_busy[1] !== 1'b0 || o_ep[1] !== 16'd3) begin
      n_err++; $display("FAIL same_cycle_end: got busy=%b ep=%0d, required busy=0 ep=3", o_busy[1], o_ep[1]);
    end
  endtask

  task automatic test_back_to_back();
    drive_enable(2);
    for (int i = 0; i < 100; i++) begin
      tick(2);
      drive_update(2, 1'b0);
    end
    tick(3);
    n_vec++;
    if (starts_seen[2] != 100 || finishes_seen[2] != 1) begin
      n_err++; $display("FAIL pulse_counts: got starts=%0d finishes=%0d, required 100 and 1",
                        starts_seen[2], finishes_seen[2]);
    end
    n_vec++;
    if (o_busy[2] !== 1'b0 || o_ep[2] !== 16'd100) begin
      n_err++; $display("FAIL many_end: got busy=%b ep=%0d, required busy=0 ep=100", o_busy[2], o_ep[2]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; vst[d] = 1'b0; upd[d] = 1'b0; st[d] = 4'h0;
      m_steps[d] = 0; m_goal[d] = 1'b0; m_ep[d] = 0; m_run[d] = 1'b0;
      starts_seen[d] = 0; finishes_seen[d] = 0; last_at[d] = 2'b00;
    end
    test_reset();
    test_first_issue();
    test_step_cap();
    test_ignored_inputs();
    test_reset_mid_run();
    test_goal();
    test_same_cycle_goal();
    test_back_to_back();
    tick(3);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL pending_pulses: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
